// File: rtl/dmem_if.sv
// Request/response bundle between the MEM-stage initiator and the data-memory responder.
interface dmem_if;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic        mem_resp;
    logic [15:0] mem_rdata;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_resp, mem_rdata
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_resp, mem_rdata
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency word-organised data memory answering LC-3b MEM-stage requests.
// Optional read/write completion counters are built when DMEM_STATS_EN is defined.
module dmem_responder #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    dmem_if.slave       mem
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] read_count,
    output logic [15:0] write_count
`endif
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 32'(1) << ADDR_BITS;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic                 is_write;
        logic [ADDR_BITS-1:0] idx;
        logic [DATA_W-1:0]    wdata;
        logic [1:0]           be;
    } req_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    req_t               cap_q, cap_d;
    logic               resp_q, resp_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [DATA_W-1:0]  storage [DEPTH];

    // Address bit 0 and bits above the index alias by design.
    logic unused_addr;
    assign unused_addr = ^mem.mem_address;

    assign mem.mem_resp  = resp_q;
    assign mem.mem_rdata = rdata_q;

    // Next-state, capture and registered-output staging.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        resp_d  = 1'b0;
        rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (mem.mem_read || mem.mem_write) begin
                    cap_d.is_write = mem.mem_write;
                    cap_d.idx      = mem.mem_address[ADDR_BITS:1];
                    cap_d.wdata    = mem.mem_wdata;
                    cap_d.be       = mem.mem_byte_enable;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Read data is sampled on entry to RESP, so a read+write returns the pre-write word.
        if (state_d == RESP) begin
            resp_d  = 1'b1;
            rdata_d = storage[cap_d.idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    // Write commits on the edge leaving RESP; reset clears every word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (state_q == RESP && cap_q.is_write) begin
            if (cap_q.be[0]) storage[cap_q.idx][7:0]  <= cap_q.wdata[7:0];
            if (cap_q.be[1]) storage[cap_q.idx][15:8] <= cap_q.wdata[15:8];
        end
    end

`ifdef DMEM_STATS_EN
    // Saturating completion counters; a read+write request counts as a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_count  <= '0;
            write_count <= '0;
        end else if (state_q == RESP) begin
            if (cap_q.is_write) begin
                if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
            end else begin
                if (read_count != 16'hFFFF) read_count <= read_count + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder at LATENCY=3 (dut 0) and LATENCY=1 (dut 1),
// checked against an array-based memory model.
module tb_dmem_responder;
    localparam int LAT0 = 3;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       rd, wr, resp;
    logic [1:0][15:0] addr, wdata, rdata;
    logic [1:0][1:0]  be;
`ifdef DMEM_STATS_EN
    logic [1:0][15:0] rc, wc;
`endif

    dmem_if b0 ();
    dmem_if b1 ();

    assign b0.mem_read        = rd[0];
    assign b0.mem_write       = wr[0];
    assign b0.mem_address     = addr[0];
    assign b0.mem_wdata       = wdata[0];
    assign b0.mem_byte_enable = be[0];
    assign resp[0]            = b0.mem_resp;
    assign rdata[0]           = b0.mem_rdata;

    assign b1.mem_read        = rd[1];
    assign b1.mem_write       = wr[1];
    assign b1.mem_address     = addr[1];
    assign b1.mem_wdata       = wdata[1];
    assign b1.mem_byte_enable = be[1];
    assign resp[1]            = b1.mem_resp;
    assign rdata[1]           = b1.mem_rdata;

    dmem_responder #(.ADDR_BITS(8), .LATENCY(LAT0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .mem (b0)
`ifdef DMEM_STATS_EN
        ,
        .read_count  (rc[0]),
        .write_count (wc[0])
`endif
    );

    dmem_responder #(.ADDR_BITS(8), .LATENCY(LAT1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .mem (b1)
`ifdef DMEM_STATS_EN
        ,
        .read_count  (rc[1]),
        .write_count (wc[1])
`endif
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model [2][256];
    int          rd_n [2];
    int          wr_n [2];
    logic [15:0] got;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int s);
        return (s == 0) ? LAT0 : LAT1;
    endfunction

    task automatic clear_model();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) model[s][i] = 16'h0000;
            rd_n[s] = 0;
            wr_n[s] = 0;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        rd  = '0;
        wr  = '0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    // Idle cycles: no response pulse and rdata held at zero on both responders.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check("idle_resp", 32'(resp), 32'(0));
            check("idle_rdata", 32'(rdata), 32'(0));
        end
    endtask

    // Called at a falling edge; chained means the same responder showed resp at this edge.
    task automatic do_op(input int s, input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic [1:0] b, input bit chained,
                         input string tag, output logic [15:0] rdv);
        int          idx;
        int          exp_lat;
        int          k;
        logic [15:0] old;
        logic [15:0] m;
        idx     = int'(a >> 1) % 256;
        old     = model[s][idx];
        exp_lat = lat_of(s) + (chained ? 1 : 0);
        addr[s] = a;
        wdata[s] = d;
        be[s]   = b;
        rd[s]   = r;
        wr[s]   = w;
        k       = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (resp[s]) begin
                k = c;
                break;
            end
        end
        check({tag, "_lat"}, 32'(k), 32'(exp_lat));
        rdv = rdata[s];
        if (r && k != 0) check({tag, "_rdata"}, 32'(rdv), 32'(old));
        if (w) begin
            m = old;
            if (b[0]) m = (m & 16'hFF00) | (d & 16'h00FF);
            if (b[1]) m = (m & 16'h00FF) | (d & 16'hFF00);
            model[s][idx] = m;
            wr_n[s]++;
        end else begin
            rd_n[s]++;
        end
        rd[s] = 1'b0;
        wr[s] = 1'b0;
    endtask

    initial begin
        int          s;
        int          last_s;
        bit          just_done;
        logic [1:0]  op;
        logic [15:0] a;

        rst   = 1'b1;
        rd    = '0;
        wr    = '0;
        addr  = '0;
        wdata = '0;
        be    = '0;
        do_reset(2);
        check("rst_resp", 32'(resp), 32'(0));
        check("rst_rdata", 32'(rdata), 32'(0));

        do_op(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, 1'b0, "rd_after_rst", got);
        check("rd_after_rst_val", 32'(got), 32'h0000);
        idle(1);

        do_op(0, 1'b0, 1'b1, 16'h0020, 16'hBEEF, 2'b11, 1'b0, "wr_beef", got);
        idle(1);
        do_op(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0, "rd_beef", got);
        check("rd_beef_val", 32'(got), 32'hBEEF);
        idle(1);

        do_op(0, 1'b0, 1'b1, 16'h0040, 16'h1234, 2'b11, 1'b0, "wr_1234", got);
        idle(1);
        do_op(0, 1'b0, 1'b1, 16'h0040, 16'hAACD, 2'b01, 1'b0, "wr_lo", got);
        idle(1);
        do_op(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 1'b0, "rd_lo", got);
        check("byte_lo_val", 32'(got), 32'h12CD);
        idle(1);
        do_op(0, 1'b0, 1'b1, 16'h0040, 16'h77FF, 2'b10, 1'b0, "wr_hi", got);
        idle(1);
        do_op(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 1'b0, "rd_hi", got);
        check("byte_hi_val", 32'(got), 32'h77CD);
        idle(1);

        do_op(0, 1'b1, 1'b1, 16'h0040, 16'h1111, 2'b11, 1'b0, "rw_both", got);
        check("rw_prewrite_val", 32'(got), 32'h77CD);
        idle(1);
        do_op(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b11, 1'b0, "rd_after_rw", got);
        check("rd_after_rw_val", 32'(got), 32'h1111);
        idle(1);

        do_op(0, 1'b0, 1'b1, 16'h0003, 16'h5A5A, 2'b11, 1'b0, "wr_alias", got);
        idle(1);
        do_op(0, 1'b1, 1'b0, 16'h0202, 16'h0000, 2'b00, 1'b0, "rd_alias", got);
        check("alias_val", 32'(got), 32'h5A5A);
        idle(1);

        // Abort a write from WAIT with a reset.
        addr[0]  = 16'h0008;
        wdata[0] = 16'hFFFF;
        be[0]    = 2'b11;
        wr[0]    = 1'b1;
        @(negedge clk);
        check("abort_wait_resp", 32'(resp), 32'(0));
        rst   = 1'b1;
        wr[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        idle(5);
        do_op(0, 1'b1, 1'b0, 16'h0008, 16'h0000, 2'b00, 1'b0, "rd_abort", got);
        check("abort_val", 32'(got), 32'h0000);
        idle(1);

        // LATENCY=1 back-to-back traffic.
        do_op(1, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b0, "b2b_first", got);
        do_op(1, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b1, "b2b_second", got);
        do_op(1, 1'b0, 1'b1, 16'h0030, 16'hC0DE, 2'b11, 1'b1, "b2b_wr1", got);
        do_op(1, 1'b0, 1'b1, 16'h0032, 16'h4321, 2'b11, 1'b1, "b2b_wr2", got);
        do_op(1, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 1'b1, "b2b_rd", got);
        check("b2b_rd_val", 32'(got), 32'hC0DE);
        idle(1);
`ifdef DMEM_STATS_EN
        check("stats1_read", 32'(rc[1]), 32'(3));
        check("stats1_write", 32'(wc[1]), 32'(2));
        check("stats0_read", 32'(rc[0]), 32'(rd_n[0]));
        check("stats0_write", 32'(wc[0]), 32'(wr_n[0]));
`endif

        // Random traffic over a small aliased window on both responders.
        last_s    = 1;
        just_done = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                idle($urandom_range(1, 3));
                just_done = 1'b0;
            end
            s      = $urandom_range(0, 1);
            op     = 2'($urandom_range(1, 3));
            a      = 16'($urandom);
            a[8:5] = 4'h0;
            do_op(s, op[0], op[1], a, 16'($urandom), 2'($urandom), just_done && (s == last_s),
                  "rand", got);
            last_s    = s;
            just_done = 1'b1;
        end
        idle(2);
`ifdef DMEM_STATS_EN
        for (int j = 0; j < 2; j++) begin
            check("stats_read_end", 32'(rc[j]), 32'(rd_n[j]));
            check("stats_write_end", 32'(wc[j]), 32'(wr_n[j]));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the LC-3b pipeline MEM stage: it services the requests that the decoded control word raises on mem_read and mem_write.
- Holds a word-organised storage array and answers every request with a single-cycle mem_resp after a fixed, parameterised latency.
- The pipeline stalls MEM until mem_resp arrives; this block is the memory end of that handshake and stands in for the cache/physical memory in pipeline bring-up.

Parameters:
- ADDR_BITS, 8, storage depth is 2^ADDR_BITS 16-bit words; word index = mem_address[ADDR_BITS:1].
- LATENCY, 3, cycles from request acceptance to mem_resp; legal range 1..15.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- mem_read  input  1  read request, held by initiator until mem_resp
- mem_write  input  1  write request, held by initiator until mem_resp
- mem_address  input  16  byte address; bit 0 and bits above ADDR_BITS ignored (aliasing)
- mem_wdata  input  16  write data
- mem_byte_enable  input  2  bit0 = low byte, bit1 = high byte, writes only
- mem_resp  output  1  one-cycle completion pulse
- mem_rdata  output  16  read word, valid only while mem_resp=1, else 16'h0000

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - state=IDLE, mem_resp=0, mem_rdata=0, counter=0, all storage words cleared to 0.
  - rst asserted mid-transaction aborts it: no write is committed and no mem_resp is issued.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read|mem_write is high at the edge, capture address, wdata, byte_enable and op.
  - If LATENCY=1, go to RESP; else load counter=LATENCY-1 and go to WAIT.
  - With no request, remain in IDLE.
- WAIT:
  - Decrement the counter each edge; when the counter reaches 1, go to RESP on that edge.
  - Request inputs are ignored in this state (they are the captured values).
- RESP:
  - mem_resp=1 for exactly this cycle, then go to IDLE.
  - Read: mem_rdata = storage[captured index].
  - Write: storage commits at the edge leaving RESP. be[0] updates [7:0], be[1] updates [15:8]; be=00 changes nothing but still responds.
- Latency: request first seen high in cycle 0 -> mem_resp high in cycle LATENCY.
- Back-to-back: any request seen in IDLE is a new request, including one in the cycle right after RESP. The minimum request-to-request spacing is therefore LATENCY+1 cycles.
- Read and write both high: treated as a write; mem_rdata in RESP returns the pre-write word.
- Reads ignore byte_enable and always return the full word.
- Capture values are frozen in WAIT, so input changes mid-transaction have no effect.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined:
  - Adds output ports read_count[15:0] and write_count[15:0].
  - Each counter increments on the edge leaving RESP for its op type (a read+write request counts as a write).
  - Both saturate at 16'hFFFF and reset to 0 on rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: rst high 2 cycles -> mem_resp=0, mem_rdata=0; a subsequent read of address 16'h0010 returns 16'h0000.
- Write then read, LATENCY=3:
  - Write 16'hBEEF to 16'h0020 with be=11 -> mem_resp pulses in cycle 3 only.
  - Read of 16'h0020 -> mem_rdata=16'hBEEF together with resp in cycle 3.
- Byte writes:
  - Start with word 16'h1234 at 16'h0040.
  - Write 16'hAACD with be=01 -> read returns 16'h12CD.
  - Then write 16'h77FF with be=10 -> read returns 16'h77CD.
- Aliasing and ignored bit 0: write 16'h5A5A to 16'h0003, read 16'h0202 -> 16'h5A5A (ADDR_BITS=8).
- Reset mid-op: start a write of 16'hFFFF to 16'h0008, assert rst in WAIT -> no mem_resp; a read of 16'h0008 returns 16'h0000.
- LATENCY=1, back-to-back:
  - Read issued the cycle after resp -> second resp exactly 2 cycles after the first.
  - With DMEM_STATS_EN, after 3 reads and 2 writes -> read_count=3, write_count=2.
